// File: rtl/k423_id2ex_pipe.sv
// k423 ID->EX pipeline register.
// Holds the ID bundle for EX under a valid/ready handshake. When a load in EX
// writes a register that the waiting ID instruction reads, this block inserts
// LU_BUBBLES bubbles. An EX flush empties the register and blocks ID.
module k423_id2ex_pipe #(
    parameter int XLEN       = 32,
    parameter int RIDX_W     = 5,
    parameter int UOP_W      = 16,
    parameter int LU_BUBBLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_vld_i,
    output logic              id_rdy_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [UOP_W-1:0]  id_uop_i,
    input  logic              id_rs1_vld_i,
    input  logic              id_rs2_vld_i,
    input  logic [RIDX_W-1:0] id_rs1_idx_i,
    input  logic [RIDX_W-1:0] id_rs2_idx_i,
    input  logic              id_rd_vld_i,
    input  logic [RIDX_W-1:0] id_rd_idx_i,
    input  logic              id_load_i,
    input  logic              flush_i,
    output logic              ex_vld_o,
    input  logic              ex_rdy_i,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [UOP_W-1:0]  ex_uop_o,
    output logic              ex_rd_vld_o,
    output logic [RIDX_W-1:0] ex_rd_idx_o,
    output logic              ex_load_o,
    output logic [31:0]       perf_stall_cnt_o
);

    // Loaded when the load leaves EX; that edge itself is the first bubble.
    localparam logic [1:0] BCNT_LOAD = 2'(LU_BUBBLES - 1);

    logic              v_q, v_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [UOP_W-1:0]  uop_q, uop_d;
    logic              rd_vld_q, rd_vld_d, load_q, load_d;
    logic [RIDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic advance, hz_match, hazard, id_rdy, accept;

    // Handshake, hazard detection and next-state computation.
    always_comb begin
        advance  = ~v_q | ex_rdy_i;
        hz_match = v_q & load_q & rd_vld_q & (rd_idx_q != '0) & id_vld_i &
                   ((id_rs1_vld_i & (id_rs1_idx_i == rd_idx_q)) |
                    (id_rs2_vld_i & (id_rs2_idx_i == rd_idx_q)));
        hazard   = hz_match | (bcnt_q != 2'd0);
        id_rdy   = advance & ~hazard & ~flush_i;
        accept   = id_vld_i & id_rdy;

        v_d         = v_q;
        bcnt_d      = bcnt_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        uop_d       = uop_q;
        rd_vld_d    = rd_vld_q;
        rd_idx_d    = rd_idx_q;
        load_d      = load_q;
        stall_cnt_d = stall_cnt_q;

        if (flush_i) begin
            v_d    = 1'b0;
            bcnt_d = 2'd0;
        end else begin
            if (advance) begin
                v_d = accept;
                if (accept) begin
                    pc_d     = id_pc_i;
                    imm_d    = id_imm_i;
                    rs1_d    = id_rs1_data_i;
                    rs2_d    = id_rs2_data_i;
                    uop_d    = id_uop_i;
                    rd_vld_d = id_rd_vld_i;
                    rd_idx_d = id_rd_idx_i;
                    load_d   = id_load_i;
                end
            end
            if (hz_match & ex_rdy_i) begin
                bcnt_d = BCNT_LOAD;
            end else if ((bcnt_q != 2'd0) & advance) begin
                bcnt_d = bcnt_q - 2'd1;
            end
        end

        if (id_vld_i & ~id_rdy & ~flush_i & (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q         <= 1'b0;
            bcnt_q      <= 2'd0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            uop_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            load_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            bcnt_q      <= bcnt_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            uop_q       <= uop_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_rdy_o         = id_rdy;
    assign ex_vld_o         = v_q;
    assign ex_pc_o          = pc_q;
    assign ex_imm_o         = imm_q;
    assign ex_rs1_data_o    = rs1_q;
    assign ex_rs2_data_o    = rs2_q;
    assign ex_uop_o         = uop_q;
    assign ex_rd_vld_o      = v_q & rd_vld_q;
    assign ex_rd_idx_o      = rd_idx_q;
    assign ex_load_o        = v_q & load_q;
    assign perf_stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_k423_id2ex_pipe.sv
// Directed bench: two instances (LU_BUBBLES = 1 and 3) share one stimulus.
module tb_k423_id2ex_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i, id_vld_i, flush_i, ex_rdy_i;
    logic [31:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i;
    logic [15:0] id_uop_i;
    logic        id_rs1_vld_i, id_rs2_vld_i, id_rd_vld_i, id_load_i;
    logic [4:0]  id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i;

    logic        a_id_rdy, a_vld, a_rd_vld, a_load;
    logic [31:0] a_pc, a_imm, a_rs1, a_rs2, a_stall;
    logic [15:0] a_uop;
    logic [4:0]  a_rd_idx;
    logic        b_id_rdy, b_vld, b_rd_vld, b_load;
    logic [31:0] b_pc, b_imm, b_rs1, b_rs2, b_stall;
    logic [15:0] b_uop;
    logic [4:0]  b_rd_idx;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    k423_id2ex_pipe #(.LU_BUBBLES(1)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .id_vld_i(id_vld_i), .id_rdy_o(a_id_rdy),
        .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_rs1_data_i(id_rs1_data_i),
        .id_rs2_data_i(id_rs2_data_i), .id_uop_i(id_uop_i),
        .id_rs1_vld_i(id_rs1_vld_i), .id_rs2_vld_i(id_rs2_vld_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
        .id_rd_vld_i(id_rd_vld_i), .id_rd_idx_i(id_rd_idx_i), .id_load_i(id_load_i),
        .flush_i(flush_i), .ex_vld_o(a_vld), .ex_rdy_i(ex_rdy_i),
        .ex_pc_o(a_pc), .ex_imm_o(a_imm), .ex_rs1_data_o(a_rs1), .ex_rs2_data_o(a_rs2),
        .ex_uop_o(a_uop), .ex_rd_vld_o(a_rd_vld), .ex_rd_idx_o(a_rd_idx),
        .ex_load_o(a_load), .perf_stall_cnt_o(a_stall)
    );

    k423_id2ex_pipe #(.LU_BUBBLES(3)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .id_vld_i(id_vld_i), .id_rdy_o(b_id_rdy),
        .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_rs1_data_i(id_rs1_data_i),
        .id_rs2_data_i(id_rs2_data_i), .id_uop_i(id_uop_i),
        .id_rs1_vld_i(id_rs1_vld_i), .id_rs2_vld_i(id_rs2_vld_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
        .id_rd_vld_i(id_rd_vld_i), .id_rd_idx_i(id_rd_idx_i), .id_load_i(id_load_i),
        .flush_i(flush_i), .ex_vld_o(b_vld), .ex_rdy_i(ex_rdy_i),
        .ex_pc_o(b_pc), .ex_imm_o(b_imm), .ex_rs1_data_o(b_rs1), .ex_rs2_data_o(b_rs2),
        .ex_uop_o(b_uop), .ex_rd_vld_o(b_rd_vld), .ex_rd_idx_o(b_rd_idx),
        .ex_load_o(b_load), .perf_stall_cnt_o(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Present one ID instruction; payload derived from PC so captures are traceable.
    task automatic drive(input logic vld, input logic [31:0] pc,
                         input logic r1v, input logic [4:0] r1,
                         input logic r2v, input logic [4:0] r2,
                         input logic rdv, input logic [4:0] rd, input logic ld);
        id_vld_i      = vld;
        id_pc_i       = pc;
        id_imm_i      = pc + 32'h100;
        id_rs1_data_i = pc ^ 32'hA5A5_0000;
        id_rs2_data_i = pc ^ 32'h0000_5A5A;
        id_uop_i      = pc[15:0] + 16'h7;
        id_rs1_vld_i  = r1v;
        id_rs1_idx_i  = r1;
        id_rs2_vld_i  = r2v;
        id_rs2_idx_i  = r2;
        id_rd_vld_i   = rdv;
        id_rd_idx_i   = rd;
        id_load_i     = ld;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ex_rdy_i = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(); cyc();
        chk("rst_vld", {31'd0, a_vld}, 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_rd_vld", {31'd0, a_rd_vld}, 32'd0);
        chk("rst_stall", a_stall, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_id_rdy", {31'd0, a_id_rdy}, 32'd1);

        // Streaming ALU instructions, one per cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0);
            cyc();
            chk("stream_vld", {31'd0, a_vld}, 32'd1);
            chk("stream_pc", a_pc, 32'(i * 4));
        end
        chk("stream_imm", a_imm, 32'h10C);
        chk("stream_rs2", a_rs2, 32'h0000_5A56);
        chk("stream_uop", {16'd0, a_uop}, 32'h13);
        chk("stream_stall", a_stall, 32'd0);

        // EX backpressure: 0x10 held for 3 cycles while 0x14 waits.
        drive(1'b1, 32'h10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
        cyc();
        ex_rdy_i = 1'b0;
        drive(1'b1, 32'h14, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_rdy", {31'd0, a_id_rdy}, 32'd0);
            cyc();
            chk("bp_pc", a_pc, 32'h10);
        end
        chk("bp_stall", a_stall, 32'd3);
        ex_rdy_i = 1'b1;
        #1;
        chk("bp_resume_rdy", {31'd0, a_id_rdy}, 32'd1);
        cyc();
        chk("bp_resume_pc", a_pc, 32'h14);
        id_vld_i = 1'b0;
        cyc();
        chk("bp_drain_vld", {31'd0, a_vld}, 32'd0);
        chk("bp_stall_b", b_stall, 32'd3);

        // Load-use on rs2: LU=1 gives 1 bubble, LU=3 gives 3.
        drive(1'b1, 32'h20, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
        cyc();
        chk("lu_load_a", {31'd0, a_load}, 32'd1);
        chk("lu_load_b", {31'd0, b_load}, 32'd1);
        drive(1'b1, 32'h24, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
        #1;
        chk("lu_rdy_a", {31'd0, a_id_rdy}, 32'd0);
        chk("lu_rdy_b", {31'd0, b_id_rdy}, 32'd0);
        cyc();
        chk("lu_e1_vld_a", {31'd0, a_vld}, 32'd0);
        chk("lu_e1_rdvld_a", {31'd0, a_rd_vld}, 32'd0);
        chk("lu_e1_load_a", {31'd0, a_load}, 32'd0);
        chk("lu_e1_vld_b", {31'd0, b_vld}, 32'd0);
        cyc();
        chk("lu_e2_vld_a", {31'd0, a_vld}, 32'd1);
        chk("lu_e2_pc_a", a_pc, 32'h24);
        chk("lu_e2_vld_b", {31'd0, b_vld}, 32'd0);
        cyc();
        chk("lu_e3_vld_b", {31'd0, b_vld}, 32'd0);
        cyc();
        chk("lu_e4_vld_b", {31'd0, b_vld}, 32'd1);
        chk("lu_e4_pc_b", b_pc, 32'h24);
        chk("lu_stall_a", a_stall, 32'd4);
        chk("lu_stall_b", b_stall, 32'd6);

        // Load to x0 never interlocks.
        drive(1'b1, 32'h30, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        cyc();
        drive(1'b1, 32'h34, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b0);
        #1;
        chk("x0_rdy_b", {31'd0, b_id_rdy}, 32'd1);
        cyc();
        chk("x0_pc_b", b_pc, 32'h34);
        chk("x0_vld_b", {31'd0, b_vld}, 32'd1);

        // Flush with v=1, ex_rdy=1 and a valid ID bundle.
        drive(1'b1, 32'h40, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        cyc();
        flush_i = 1'b1;
        drive(1'b1, 32'h44, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        #1;
        chk("fl_rdy", {31'd0, a_id_rdy}, 32'd0);
        cyc();
        chk("fl_vld", {31'd0, a_vld}, 32'd0);
        chk("fl_stall", a_stall, 32'd4);
        flush_i = 1'b0;
        cyc();
        chk("fl_after_pc", a_pc, 32'h44);

        // Flush after the first of three bubbles (rs1 and rs2 both hit).
        drive(1'b1, 32'h50, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
        cyc();
        drive(1'b1, 32'h54, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd9, 1'b0);
        cyc();
        chk("flb_e1_vld_b", {31'd0, b_vld}, 32'd0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        chk("flb_rdy_b", {31'd0, b_id_rdy}, 32'd1);
        cyc();
        chk("flb_vld_b", {31'd0, b_vld}, 32'd1);
        chk("flb_pc_b", b_pc, 32'h54);

        // Saturation: preload near max during a backpressure stall.
        ex_rdy_i = 1'b0;
        drive(1'b1, 32'h58, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        force dut_a.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut_a.stall_cnt_q;
        cyc();
        chk("sat_max", a_stall, 32'hFFFF_FFFF);
        cyc();
        chk("sat_hold", a_stall, 32'hFFFF_FFFF);
        ex_rdy_i = 1'b1;
        cyc();

        // Reset in the middle of a bubble sequence.
        drive(1'b1, 32'h60, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
        cyc();
        drive(1'b1, 32'h64, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("rstb_vld_b", {31'd0, b_vld}, 32'd0);
        chk("rstb_stall_a", a_stall, 32'd0);
        #1;
        chk("rstb_rdy_b", {31'd0, b_id_rdy}, 32'd1);
        cyc();
        chk("rstb_pc_b", b_pc, 32'h64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
